clkdiv_cfg_ctrl: RTL and testbench

Software-facing configuration stage that sits directly upstream of the odd clock divider and drives its divide value and reset.
It accepts new divide values over a valid/ready handshake and rejects illegal values.
It applies each legal value glitch-free: it holds the divider in reset for a few cycles, starting only while the divided clock is low, then releases it with the new value.
A shadow phase counter mirrors the divider's posedge counter so the block knows when the divided clock is low.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_cfg_ctrl.sv | 117 +++++++++++
 tb/tb_clkdiv_cfg_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock-divider configuration stage.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitSafe,
        StHold
    } state_e;

    // Phase at which both divider counters sit at or below half, so clkout is low.
    localparam int unsigned SAFE_PHASE = 1;

    function automatic logic is_legal_div(input logic [31:0] value);
        return value[0] && (value >= 32'd3);
    endfunction

endpackage

// File: rtl/clkdiv_cfg_ctrl.sv
// Accepts divide values over valid/ready and applies legal ones to the odd divider
// by holding it in reset while its output is low.
module clkdiv_cfg_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W       = 4,
    parameter int unsigned DEFAULT_DIV = 3,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             cfg_done,
    output logic             busy,
    output logic [DIV_W-1:0] divbyvalue,
    output logic             div_rstn
);

    localparam logic [DIV_W-1:0] DefaultDiv = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] SafePhase  = DIV_W'(SAFE_PHASE);
    localparam logic [DIV_W-1:0] One        = DIV_W'(1);
    localparam logic [3:0]       HoldLoad   = 4'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [3:0]       hold_q, hold_d;
    logic             div_rstn_q, div_rstn_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    // div_rstn_q gates ready so nothing is accepted until the divider has left reset.
    assign cfg_ready  = (state_q == StIdle) && div_rstn_q;
    assign busy       = (state_q != StIdle);
    assign cfg_err    = err_q;
    assign cfg_done   = done_q;
    assign divbyvalue = div_q;
    assign div_rstn   = div_rstn_q;

    // Shadow of the divider's posedge counter.
    always_comb begin
        phase_d = '0;
        if (div_rstn_q) begin
            phase_d = (phase_q == div_q - One) ? '0 : phase_q + One;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        hold_d     = hold_q;
        div_d      = div_q;
        div_rstn_d = div_rstn_q;
        err_d      = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                div_rstn_d = 1'b1;
                if (cfg_valid && cfg_ready) begin
                    if (!is_legal_div(32'(cfg_div))) begin
                        err_d = 1'b1;
                    end else if (cfg_div == div_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = cfg_div;
                        state_d = StWaitSafe;
                    end
                end
            end
            StWaitSafe: begin
                if (phase_q == SafePhase) begin
                    div_rstn_d = 1'b0;
                    div_d      = pend_q;
                    hold_d     = HoldLoad;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (hold_q == 4'd0) begin
                    div_rstn_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            div_q      <= DefaultDiv;
            pend_q     <= DefaultDiv;
            hold_q     <= 4'd0;
            div_rstn_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            div_rstn_q <= div_rstn_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Bench for clkdiv_cfg_ctrl: schedule-based reference model checked every cycle,
// plus directed scenarios with literal expectations and an odd-divider model for clkout.
module tb_clkdiv_cfg_ctrl;

    localparam int DIV_W       = 4;
    localparam int DEFAULT_DIV = 3;
    localparam int HOLD_CYCLES = 2;

    logic             clkin = 1'b0;
    logic             rstn = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_ready, cfg_err, cfg_done, busy, div_rstn;
    logic [DIV_W-1:0] divbyvalue;

    int n_checks = 0;
    int n_pass   = 0;

    clkdiv_cfg_ctrl #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_dut (
        .clkin     (clkin),
        .rstn      (rstn),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cfg_done  (cfg_done),
        .busy      (busy),
        .divbyvalue(divbyvalue),
        .div_rstn  (div_rstn)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Odd divider driven by the DUT: posedge counter plus a negedge-retimed copy.
    int   cnt_p = 0;
    int   cnt_n = 0;
    logic clkout;
    always @(posedge clkin or negedge div_rstn) begin
        if (!div_rstn) cnt_p <= 0;
        else cnt_p <= (cnt_p >= int'(divbyvalue) - 1) ? 0 : cnt_p + 1;
    end
    always @(negedge clkin or negedge div_rstn) begin
        if (!div_rstn) cnt_n <= 0;
        else cnt_n <= cnt_p;
    end
    assign clkout = (cnt_p > int'(divbyvalue) / 2) || (cnt_n > int'(divbyvalue) / 2);

    int low_cycles = 0;
    always @(negedge clkin) begin
        if (rstn && !div_rstn) low_cycles <= low_cycles + 1;
    end

    // Reference model: tracks edge count and schedules the div_rstn fall/rise arithmetically.
    int m_div, m_ph, m_pend, m_fall, m_rise, m_n;
    bit m_rstn, m_busy, m_err, m_done;

    task model_reset();
        m_div  = DEFAULT_DIV;
        m_ph   = 0;
        m_pend = DEFAULT_DIV;
        m_fall = -1;
        m_rise = -1;
        m_n    = 0;
        m_rstn = 0;
        m_busy = 0;
        m_err  = 0;
        m_done = 0;
    endtask

    task model_step(input bit v, input int d);
        bit xfer;
        int ph_n;
        int j;
        xfer = v && m_rstn && !m_busy;
        ph_n = m_rstn ? ((m_ph == m_div - 1) ? 0 : m_ph + 1) : 0;
        m_n++;
        m_err  = 0;
        m_done = 0;
        if (!m_rstn && !m_busy) begin
            m_rstn = 1;
        end else if (m_busy && m_n == m_fall) begin
            m_rstn = 0;
            m_div  = m_pend;
        end else if (m_busy && m_n == m_rise) begin
            m_rstn = 1;
            m_done = 1;
            m_busy = 0;
        end
        if (xfer) begin
            if (d % 2 == 0 || d < 3) begin
                m_err = 1;
            end else if (d == m_div) begin
                m_done = 1;
            end else begin
                m_busy = 1;
                m_pend = d;
                j      = (1 - ph_n + m_div) % m_div;
                m_fall = m_n + 1 + j;
                m_rise = m_fall + HOLD_CYCLES;
            end
        end
        m_ph = ph_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clkin);
            if (!rstn) model_reset();
            else model_step(cfg_valid, int'(cfg_div));
            #1;
            chk("m_divbyvalue", divbyvalue, m_div);
            chk("m_div_rstn", div_rstn, m_rstn);
            chk("m_cfg_ready", cfg_ready, m_rstn && !m_busy);
            chk("m_busy", busy, m_busy);
            chk("m_cfg_err", cfg_err, m_err);
            chk("m_cfg_done", cfg_done, m_done);
            chk("m_err_done_excl", cfg_err && cfg_done, 0);
        end
    end

    bit last_err, last_done;

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input int v, output int stalls);
        bit ok, got;
        stalls    = 0;
        got       = 0;
        cfg_valid = 1'b1;
        cfg_div   = 4'(v);
        for (int i = 0; i < 64 && !got; i++) begin
            ok = cfg_ready;
            if (!ok) stalls++;
            @(posedge clkin);
            if (ok) got = 1;
            @(negedge clkin);
        end
        if (!got) chk("send_timeout", 0, 1);
        last_err  = cfg_err;
        last_done = cfg_done;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clkin);
            if (cfg_done) return;
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    // Half-cycle samples of clkout: high time and period between rising edges.
    task automatic measure(output int hi, output int per);
        logic prev;
        bit   found;
        hi    = 0;
        per   = 0;
        found = 0;
        prev  = clkout;
        for (int i = 0; i < 200 && !found; i++) begin
            @(clkin);
            #1;
            if (!prev && clkout) found = 1;
            prev = clkout;
        end
        if (!found) begin
            chk("measure_timeout", 0, 1);
            return;
        end
        per = 1;
        hi  = 1;
        for (int i = 0; i < 200; i++) begin
            @(clkin);
            #1;
            if (!prev && clkout) break;
            per++;
            if (clkout) hi++;
            prev = clkout;
        end
    endtask

    int   st, lowc, low0, hi, per;
    logic prev_clk;
    int   ill[4] = '{0, 1, 8, 14};

    initial begin
        repeat (3) @(negedge clkin);
        chk("rst_divbyvalue", divbyvalue, 3);
        chk("rst_div_rstn", div_rstn, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1;
        @(negedge clkin);
        chk("rel_div_rstn", div_rstn, 1);
        chk("rel_ready", cfg_ready, 1);
        chk("rel_no_pulse", cfg_err | cfg_done, 0);
        repeat (5) @(negedge clkin);

        // 3 -> 7
        send(7, st);
        lowc     = 0;
        prev_clk = clkout;
        for (int i = 0; i < 40; i++) begin
            @(negedge clkin);
            if (!div_rstn) begin
                lowc++;
                if (lowc == 1) begin
                    chk("upd7_div_at_fall", divbyvalue, 7);
                    chk("upd7_clk_low_before_fall", prev_clk, 0);
                end
            end
            prev_clk = clkout;
            if (cfg_done) break;
        end
        chk("upd7_low_cycles", lowc, 2);
        chk("upd7_done", cfg_done, 1);
        repeat (10) @(negedge clkin);
        measure(hi, per);
        chk("upd7_clk_high_halves", hi, 7);
        chk("upd7_clk_period_halves", per, 14);
        @(negedge clkin);

        // illegal values
        low0 = low_cycles;
        for (int i = 0; i < 4; i++) begin
            send(ill[i], st);
            chk("ill_err", last_err, 1);
            chk("ill_done", last_done, 0);
        end
        repeat (2) @(negedge clkin);
        chk("ill_div_kept", divbyvalue, 7);
        chk("ill_no_div_rst", low_cycles - low0, 0);

        // back-to-back 9 then 15
        send(9, st);
        send(15, st);
        chk("b2b_stalled", st > 0, 1);
        chk("b2b_first_applied", divbyvalue, 9);
        wait_done("b2b");
        @(negedge clkin);
        chk("b2b_final", divbyvalue, 15);

        // same value
        send(5, st);
        wait_done("to5");
        repeat (3) @(negedge clkin);
        low0 = low_cycles;
        send(5, st);
        chk("same_done", last_done, 1);
        chk("same_busy", busy, 0);
        repeat (5) @(negedge clkin);
        chk("same_no_div_rst", low_cycles - low0, 0);
        chk("same_div", divbyvalue, 5);

        // reset during HOLD of 3 -> 11
        send(3, st);
        wait_done("to3");
        repeat (2) @(negedge clkin);
        send(11, st);
        for (int i = 0; i < 40; i++) begin
            if (!div_rstn) break;
            @(negedge clkin);
        end
        chk("midhold_in_hold", div_rstn, 0);
        rstn = 1'b0;
        #1;
        chk("midhold_div", divbyvalue, 3);
        chk("midhold_div_rstn", div_rstn, 0);
        chk("midhold_busy", busy, 0);
        chk("midhold_ready", cfg_ready, 0);
        repeat (3) @(negedge clkin);
        rstn = 1'b1;
        repeat (2) @(negedge clkin);
        chk("post_rst_ready", cfg_ready, 1);
        chk("post_rst_div", divbyvalue, 3);
        send(11, st);
        wait_done("after_rst");
        @(negedge clkin);
        chk("post_rst_final", divbyvalue, 11);

        repeat (3) @(negedge clkin);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
